instr_fetch_unit: RTL

Instruction-fetch stage of the 4-bit MIPS unicycle datapath. It owns the program counter, issues one request at a time to instruction memory over a req/ack handshake, and presents the fetched word to decode over a valid/ready handshake. It also consumes the branch decision (the Branch AND Zero result) and the jump controls to select the next PC.

---
 rtl/instr_fetch_unit_pkg.sv | 16 +
 rtl/instr_fetch_unit_pc_next_calc.sv | 29 ++
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage: FSM state encoding,
// default reset PC and timeout, and the width of the request wait counter.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    RETRY = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  localparam int DEF_RESET_PC = 0;
  localparam int DEF_TIMEOUT  = 15;
  localparam int WAIT_CNT_W   = 8;

endpackage

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Next-PC selection: jump beats branch, branch adds a signed word offset to pc+1.
// All arithmetic wraps modulo 2^PC_W.
module pc_next_calc
  import fetch_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic            br_take,
  input  logic [PC_W-1:0] br_offset,
  input  logic            jmp_en,
  input  logic [PC_W-1:0] jmp_target,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] seq_pc;

  always_comb begin
    seq_pc = pc + PC_W'(1);
    if (jmp_en) begin
      next_pc = jmp_target;
    end else if (br_take) begin
      next_pc = seq_pc + br_offset;
    end else begin
      next_pc = seq_pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a req/ack fetch with timeout and
// retry, and hands the fetched word to decode over a valid/ready handshake.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = DEF_RESET_PC,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [PC_W-1:0]    pc,
  input  logic               br_take,
  input  logic [PC_W-1:0]    br_offset,
  input  logic               jmp_en,
  input  logic [PC_W-1:0]    jmp_target,
  output logic               fetch_err
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST  = WAIT_CNT_W'(TIMEOUT - 1);
  localparam logic [PC_W-1:0]       RESET_ADDR = PC_W'(RESET_PC);

  fetch_state_e          state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [PC_W-1:0]       fetch_addr_q, fetch_addr_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [INSTR_W-1:0]    ir_q, ir_d;
  logic [PC_W-1:0]       next_pc;

  pc_next_calc #(.PC_W(PC_W)) u_pc_next_calc (
    .pc         (pc_q),
    .br_take    (br_take),
    .br_offset  (br_offset),
    .jmp_en     (jmp_en),
    .jmp_target (jmp_target),
    .next_pc    (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      wait_cnt_q   <= '0;
      fetch_addr_q <= RESET_ADDR;
      pc_q         <= RESET_ADDR;
      ir_q         <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
    end
  end

  // An ack in the final wait cycle takes priority over the timeout.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    case (state_q)
      BOOT: begin
        fetch_addr_d = RESET_ADDR;
        wait_cnt_d   = '0;
        state_d      = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          ir_d       = imem_data;
          pc_d       = fetch_addr_q;
          wait_cnt_d = '0;
          state_d    = HOLD;
        end else if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          state_d    = RETRY;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      RETRY: begin
        state_d = FETCH;
      end
      HOLD: begin
        if (ir_ready) begin
          fetch_addr_d = next_pc;
          state_d      = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    imem_req  = (state_q == FETCH);
    fetch_err = (state_q == RETRY);
    ir_valid  = (state_q == HOLD);
    imem_addr = fetch_addr_q;
    ir        = ir_q;
    pc        = pc_q;
  end

endmodule
